k_counter_filter: RTL and testbench

//   Loop filter of the DPLL. Feeds the inc/dec pulse inputs of the ID counter stage.

---
 rtl/dpll_pkg.sv | 13 +
 rtl/kfilt_holdoff_timer.sv | 41 ++++
 rtl/k_counter_filter.sv | 116 +++++++++++
 tb/tb_k_counter_filter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared DPLL defaults and step-direction encoding
package dpll_pkg;

  localparam int K_WIDTH_DEF = 4;
  localparam int HOLDOFF_DEF = 3;
  localparam int STATS_W     = 16;

  typedef enum logic {
    STEP_UP = 1'b0,
    STEP_DN = 1'b1
  } step_dir_e;

endpackage

// File: rtl/kfilt_holdoff_timer.sv
// rtl/kfilt_holdoff_timer.sv - holdoff countdown that paces loop-filter pulses
module kfilt_holdoff_timer #(
  parameter int HOLDOFF = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic hold_o,
  output logic busy_o
);

  localparam int TW = $clog2(HOLDOFF + 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          busy_q;

  always_comb begin
    tmr_d = tmr_q;
    if (load_i) begin
      tmr_d = TW'(HOLDOFF);
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      busy_q <= (tmr_q != '0);
    end
  end

  // hold_o leads busy_o by one cycle: a decision made while hold_o is low lands
  // its pulse on the first cycle after busy has dropped.
  assign hold_o = (tmr_q != '0);
  assign busy_o = busy_q;

endmodule

// File: rtl/k_counter_filter.sv
// rtl/k_counter_filter.sv - DPLL K-counter loop filter; KFILT_STATS_EN adds pulse totals
module k_counter_filter
  import dpll_pkg::*;
#(
  parameter int K_WIDTH = K_WIDTH_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         dn_up,
  input  logic [$clog2(K_WIDTH+1)-1:0] k_sel,
  output logic                         inc,
  output logic                         dec,
  output logic                         busy,
  output logic signed [K_WIDTH:0]      cnt
`ifdef KFILT_STATS_EN
  ,
  output logic [STATS_W-1:0]           inc_total,
  output logic [STATS_W-1:0]           dec_total
`endif
);

  localparam int CW  = K_WIDTH + 1;
  localparam int KSW = $clog2(K_WIDTH + 1);

  logic signed [CW-1:0] cnt_q, cnt_d, lim, neg_lim;
  logic                 inc_q, inc_d, dec_q, dec_d;
  logic                 hold;
  logic [KSW-1:0]       k_eff;

  always_comb begin
    k_eff = k_sel;
    if (k_sel == '0) begin
      k_eff = KSW'(1);
    end else if (k_sel > KSW'(K_WIDTH)) begin
      k_eff = KSW'(K_WIDTH);
    end
  end

  assign lim     = $signed((CW'(1) << k_eff) - CW'(1));
  assign neg_lim = -lim;

  // A threshold shrink clamps first and swallows that cycle's step, so the
  // clamp itself can never produce a pulse.
  always_comb begin
    cnt_d = cnt_q;
    inc_d = 1'b0;
    dec_d = 1'b0;
    if (cnt_q > lim) begin
      cnt_d = lim;
    end else if (cnt_q < neg_lim) begin
      cnt_d = neg_lim;
    end else if (en) begin
      if (step_dir_e'(dn_up) == STEP_UP) begin
        if (cnt_q != lim) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!hold) begin
          inc_d = 1'b1;
          cnt_d = '0;
        end
      end else begin
        if (cnt_q != neg_lim) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!hold) begin
          dec_d = 1'b1;
          cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      inc_q <= inc_d;
      dec_q <= dec_d;
    end
  end

  kfilt_holdoff_timer #(
    .HOLDOFF(HOLDOFF)
  ) u_holdoff (
    .clk   (clk),
    .reset (reset),
    .load_i(inc_d | dec_d),
    .hold_o(hold),
    .busy_o(busy)
  );

  assign inc = inc_q;
  assign dec = dec_q;
  assign cnt = cnt_q;

`ifdef KFILT_STATS_EN
  logic [STATS_W-1:0] inc_total_q, dec_total_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      inc_total_q <= '0;
      dec_total_q <= '0;
    end else begin
      if (inc_d && inc_total_q != '1) inc_total_q <= inc_total_q + STATS_W'(1);
      if (dec_d && dec_total_q != '1) dec_total_q <= dec_total_q + STATS_W'(1);
    end
  end

  assign inc_total = inc_total_q;
  assign dec_total = dec_total_q;
`endif

endmodule

// File: tb/tb_k_counter_filter.sv
// tb/tb_k_counter_filter.sv - scoreboard bench for k_counter_filter (K_WIDTH=4, HOLDOFF=3)
module tb_k_counter_filter;

  logic              clk = 1'b0;
  logic              reset, en, dn_up;
  logic [2:0]        k_sel;
  logic              inc, dec, busy;
  logic signed [4:0] cnt;
`ifdef KFILT_STATS_EN
  logic [15:0]       inc_total, dec_total;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  k_counter_filter #(.K_WIDTH(4), .HOLDOFF(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dn_up    (dn_up),
    .k_sel    (k_sel),
    .inc      (inc),
    .dec      (dec),
    .busy     (busy),
    .cnt      (cnt)
`ifdef KFILT_STATS_EN
    ,
    .inc_total(inc_total),
    .dec_total(dec_total)
`endif
  );

  // Drive one cycle of stimulus, queue the state expected after the edge, then
  // advance to 1 time unit past that edge.
  task automatic drive(input logic r, input logic e, input logic d, input logic [2:0] k,
                       input int c, input logic i, input logic dd, input logic b);
    reset = r; en = e; dn_up = d; k_sel = k;
    exp_q.push_back({5'(c), i, dd, b});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got, want;
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd2, 0, 1'b0, 1'b0, 1'b0);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_up();
    logic [7:0] got, want;
    int ec[8] = '{1, 2, 3, 0, 0, 0, 0, 0};
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, s < 4, 1'b0, 3'd2, ec[s], s == 3, 1'b0, s >= 4 && s <= 6);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL up s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_down();
    logic [7:0] got, want;
    int ec[8] = '{-1, -2, -3, 0, 0, 0, 0, 0};
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, s < 4, 1'b1, 3'd2, ec[s], 1'b0, s == 3, s >= 4 && s <= 6);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL down s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_holdoff();
    logic [7:0] got, want;
    logic       pulse, b;
    int         c;
    for (int s = 0; s < 14; s++) begin
      if (s < 10) begin
        pulse = (s == 1) || (s == 5) || (s == 9);
        b     = (s >= 2 && s <= 4) || (s >= 6 && s <= 8);
        c     = pulse ? 0 : 1;
      end else begin
        pulse = 1'b0;
        b     = (s <= 12);
        c     = 0;
      end
      drive(1'b0, s < 10, 1'b0, 3'd1, c, pulse, 1'b0, b);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL holdoff s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_ksel_bounds();
    logic [7:0] got, want;
    // k_sel=0 behaves as M=2, k_sel=5 behaves as M=16
    for (int s = 0; s < 26; s++) begin
      if (s < 6)
        drive(1'b0, s < 2, 1'b0, 3'd0, (s == 0) ? 1 : 0, s == 1, 1'b0, s >= 2 && s <= 4);
      else if (s < 22)
        drive(1'b0, 1'b1, 1'b0, 3'd5, (s < 21) ? s - 5 : 0, s == 21, 1'b0, 1'b0);
      else
        drive(1'b0, 1'b0, 1'b0, 3'd5, 0, 1'b0, 1'b0, s <= 24);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL ksel_bounds s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] got, want;
    for (int s = 0; s < 17; s++) begin
      if (s < 6)
        drive(1'b0, 1'b1, 1'b0, 3'd3, s + 1, 1'b0, 1'b0, 1'b0);
      else if (s < 8)
        drive(1'b0, 1'b0, 1'b0, 3'd1, 1, 1'b0, 1'b0, 1'b0);
      else if (s < 15)
        drive(1'b0, 1'b1, 1'b1, 3'd3, 8 - s, 1'b0, 1'b0, 1'b0);
      else
        drive(1'b0, 1'b0, 1'b0, 3'd1, -1, 1'b0, 1'b0, 1'b0);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL clamp s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, want;
    // from cnt=-1, k_sel=1: up,up,up(inc), idle, idle, reset(en=1 up), idle, up, up(inc)
    logic r[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic e[9]  = '{1, 1, 1, 0, 0, 1, 0, 1, 1};
    int   ec[9] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
    logic ei[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic eb[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    for (int s = 0; s < 9; s++) begin
      drive(r[s], e[s], 1'b0, 3'd1, ec[s], ei[s], 1'b0, eb[s]);
      got = {cnt, inc, dec, busy}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid s%0d: got cnt=%0d inc=%b dec=%b busy=%b want cnt=%0d inc=%b dec=%b busy=%b",
                 s, $signed(got[7:3]), got[2], got[1], got[0], $signed(want[7:3]), want[2], want[1], want[0]);
      end
`ifdef KFILT_STATS_EN
      if (s == 5 || s == 8) begin
        n_cmp++;
        if (inc_total !== ((s == 8) ? 16'd1 : 16'd0) || dec_total !== 16'd0) begin
          n_err++;
          $display("FAIL stats s%0d: got inc_total=%0d dec_total=%0d want inc_total=%0d dec_total=0",
                   s, inc_total, dec_total, (s == 8) ? 1 : 0);
        end
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dn_up = 1'b0; k_sel = 3'd2;
    test_reset();
    test_up();
    test_down();
    test_holdoff();
    test_ksel_bounds();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
